// File: rtl/serial_fifo_port.sv
// CPU-facing serial port front end: byte register file, TX/RX FIFOs with overflow
// flags and thresholds, masked interrupt, flush and internal loopback ahead of the UART core.
module serial_fifo_port #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       CE,
  input  logic [1:0] A,
  input  logic       WREN,
  input  logic       REN,
  input  logic [7:0] from_CPU,
  output logic [7:0] to_CPU,
  output logic       irq,
  output logic       tx_req,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  input  logic       rx_ready,
  input  logic [7:0] rx_data
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);

  typedef enum logic {IDLE, ACTIVE} tx_state_e;

  tx_state_e      state_q, state_d;
  logic [7:0]     tx_mem_q [DEPTH];
  logic [7:0]     tx_mem_d [DEPTH];
  logic [7:0]     rx_mem_q [DEPTH];
  logic [7:0]     rx_mem_d [DEPTH];
  logic [PW-1:0]  tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [PW-1:0]  rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [CW-1:0]  tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [7:0]     ctrl_q, ctrl_d, thresh_q, thresh_d;
  logic           tx_ovr_q, tx_ovr_d, rx_ovr_q, rx_ovr_d;
  logic [7:0]     to_cpu_q, to_cpu_d, tx_data_q, tx_data_d;
  logic           tx_req_q, tx_req_d;

  logic       rd, wr, status_rd, loopback;
  logic       tx_empty, tx_full, rx_empty, rx_full;
  logic       tx_flush, rx_flush, tx_push_req, tx_push, tx_pop, eng_pop, lb_xfer;
  logic       rx_push, rx_pop;
  logic       rx_thr_hit, tx_thr_hit;
  logic [7:0] rx_byte, status, rd_mux;

  always_comb begin
    rd        = CE & REN;
    wr        = CE & WREN;
    status_rd = rd & (A == 2'd1);
    loopback  = ctrl_q[5];
    tx_empty  = (tx_cnt_q == '0);
    tx_full   = (tx_cnt_q == CW'(DEPTH));
    rx_empty  = (rx_cnt_q == '0);
    rx_full   = (rx_cnt_q == CW'(DEPTH));
    tx_flush  = wr & (A == 2'd2) & from_CPU[3];
    rx_flush  = wr & (A == 2'd2) & from_CPU[4];

    // Fullness is judged on pre-edge counts; a same-cycle pop never makes room.
    tx_push_req = wr & (A == 2'd0);
    tx_push     = tx_push_req & ~tx_full;
    eng_pop     = (state_q == IDLE) & ~tx_empty & ~loopback & ~tx_flush;
    lb_xfer     = loopback & ~tx_empty & ~rx_full & ~tx_flush & ~rx_flush;
    tx_pop      = eng_pop | lb_xfer;
    rx_push     = loopback ? lb_xfer : (rx_ready & ~rx_full);
    rx_byte     = loopback ? tx_mem_q[tx_rp_q] : rx_data;
    rx_pop      = rd & (A == 2'd0) & ~rx_empty;

    rx_thr_hit = 8'(rx_cnt_q) >  {4'h0, thresh_q[3:0]};
    tx_thr_hit = 8'(tx_cnt_q) <= {4'h0, thresh_q[7:4]};
    status = {rx_thr_hit, tx_thr_hit, rx_full, tx_empty, ~rx_empty, ~tx_full, rx_ovr_q, tx_ovr_q};

    case (A)
      2'd0:    rd_mux = rx_empty ? 8'h00 : rx_mem_q[rx_rp_q];
      2'd1:    rd_mux = status;
      2'd2:    rd_mux = ctrl_q;
      default: rd_mux = thresh_q;
    endcase
    to_cpu_d = rd ? rd_mux : to_cpu_q;

    ctrl_d   = (wr & (A == 2'd2)) ? (from_CPU & 8'h27) : ctrl_q;
    thresh_d = (wr & (A == 2'd3)) ? from_CPU : thresh_q;

    // A set event in the same cycle as a STATUS read wins over the clear.
    tx_ovr_d = (tx_push_req & tx_full) | (tx_ovr_q & ~status_rd);
    rx_ovr_d = (~loopback & rx_ready & rx_full) | (rx_ovr_q & ~status_rd);

    tx_mem_d = tx_mem_q;
    if (tx_push) tx_mem_d[tx_wp_q] = from_CPU;
    rx_mem_d = rx_mem_q;
    if (rx_push) rx_mem_d[rx_wp_q] = rx_byte;

    tx_wp_d  = tx_wp_q + PW'(tx_push);
    tx_rp_d  = tx_rp_q + PW'(tx_pop);
    tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    if (tx_flush) begin
      tx_wp_d  = '0;
      tx_rp_d  = '0;
      tx_cnt_d = '0;
    end
    rx_wp_d  = rx_wp_q + PW'(rx_push);
    rx_rp_d  = rx_rp_q + PW'(rx_pop);
    rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    if (rx_flush) begin
      rx_wp_d  = '0;
      rx_rp_d  = '0;
      rx_cnt_d = '0;
    end

    // TX engine: a flush or loopback never aborts the byte already handed to the UART.
    state_d   = state_q;
    tx_req_d  = eng_pop;
    tx_data_d = eng_pop ? tx_mem_q[tx_rp_q] : tx_data_q;
    case (state_q)
      IDLE:    if (eng_pop) state_d = ACTIVE;
      default: if (tx_ready) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      tx_wp_q   <= '0;
      tx_rp_q   <= '0;
      tx_cnt_q  <= '0;
      rx_wp_q   <= '0;
      rx_rp_q   <= '0;
      rx_cnt_q  <= '0;
      ctrl_q    <= '0;
      thresh_q  <= '0;
      tx_ovr_q  <= 1'b0;
      rx_ovr_q  <= 1'b0;
      to_cpu_q  <= '0;
      tx_data_q <= '0;
      tx_req_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_wp_q   <= tx_wp_d;
      tx_rp_q   <= tx_rp_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_wp_q   <= rx_wp_d;
      rx_rp_q   <= rx_rp_d;
      rx_cnt_q  <= rx_cnt_d;
      ctrl_q    <= ctrl_d;
      thresh_q  <= thresh_d;
      tx_ovr_q  <= tx_ovr_d;
      rx_ovr_q  <= rx_ovr_d;
      to_cpu_q  <= to_cpu_d;
      tx_data_q <= tx_data_d;
      tx_req_q  <= tx_req_d;
    end
  end

  always_ff @(posedge clk) begin
    tx_mem_q <= tx_mem_d;
    rx_mem_q <= rx_mem_d;
  end

  assign to_CPU  = to_cpu_q;
  assign tx_req  = tx_req_q;
  assign tx_data = tx_data_q;
  assign irq     = (ctrl_q[0] & rx_thr_hit) | (ctrl_q[1] & tx_thr_hit) |
                   (ctrl_q[2] & (rx_ovr_q | tx_ovr_q));

endmodule

// File: tb/tb_serial_fifo_port.sv
// Directed scoreboard bench for serial_fifo_port (DEPTH=8): reads and tx_req
// pulses are checked by monitors against expected-value queues filled by the stimulus.
module tb_serial_fifo_port;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       CE = 1'b0, WREN = 1'b0, REN = 1'b0;
  logic [1:0] A = 2'd0;
  logic [7:0] from_CPU = 8'h00;
  logic [7:0] to_CPU;
  logic       irq, tx_req;
  logic [7:0] tx_data;
  logic       tx_ready = 1'b0, rx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_rd[$];
  logic [7:0] exp_tx[$];
  logic       rd_pend = 1'b0;

  serial_fifo_port #(.DEPTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .CE(CE), .A(A), .WREN(WREN), .REN(REN),
    .from_CPU(from_CPU), .to_CPU(to_CPU), .irq(irq), .tx_req(tx_req),
    .tx_data(tx_data), .tx_ready(tx_ready), .rx_ready(rx_ready), .rx_data(rx_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  // Read-data monitor: to_CPU is valid in the cycle after a CE&REN edge.
  always @(posedge clk) rd_pend <= CE & REN;
  always @(negedge clk) begin
    if (rd_pend) begin
      if (exp_rd.size() == 0) chk("rd_unexpected", to_CPU, 8'hxx);
      else chk("rd_data", to_CPU, exp_rd.pop_front());
    end
  end

  // UART-side monitor: every tx_req must match a queued byte.
  always @(negedge clk) begin
    if (reset_n && tx_req) begin
      if (exp_tx.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL tx_req_unexpected: got tx_data %02h, expected no tx_req", tx_data);
      end else chk("tx_data", tx_data, exp_tx.pop_front());
    end
  end

  task automatic idle(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    CE = 1'b1; WREN = 1'b1; A = a; from_CPU = d;
    @(posedge clk); #1;
    CE = 1'b0; WREN = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] exp);
    exp_rd.push_back(exp);
    CE = 1'b1; REN = 1'b1; A = a;
    @(posedge clk); #1;
    CE = 1'b0; REN = 1'b0;
  endtask

  task automatic rx_pulse(input logic [7:0] d);
    rx_ready = 1'b1; rx_data = d;
    @(posedge clk); #1;
    rx_ready = 1'b0;
  endtask

  task automatic tx_done();
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_to_cpu", to_CPU, 8'h00);
    chk("rst_tx_req", {7'd0, tx_req}, 8'h00);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_irq", {7'd0, irq}, 8'h00);
    reset_n = 1'b1;
    idle();

    // Reset register state.
    rd(2'd1, 8'h54);
    rd(2'd2, 8'h00);
    rd(2'd3, 8'h00);
    chk("irq_idle", {7'd0, irq}, 8'h00);

    // TX: first byte departs, the rest queue up behind the withheld tx_ready.
    exp_tx.push_back(8'h41);
    for (int i = 0; i < 8; i++) wr(2'd0, 8'h41 + 8'(i));
    wr(2'd0, 8'h49);
    rd(2'd1, 8'h00);
    wr(2'd0, 8'h4A);
    rd(2'd1, 8'h01);
    rd(2'd1, 8'h00);
    for (int i = 0; i < 8; i++) begin
      exp_tx.push_back(8'h42 + 8'(i));
      tx_done();
      idle(2);
    end
    tx_done();
    idle(3);
    rd(2'd1, 8'h54);

    // RX fill, overflow, drain and empty read.
    for (int i = 0; i < 8; i++) rx_pulse(8'h10 + 8'(i));
    rx_pulse(8'h99);
    rd(2'd1, 8'hFE);
    for (int i = 0; i < 8; i++) rd(2'd0, 8'h10 + 8'(i));
    rd(2'd0, 8'h00);
    rd(2'd1, 8'h54);

    // RX threshold interrupt.
    wr(2'd3, 8'h03);
    wr(2'd2, 8'h01);
    for (int i = 0; i < 4; i++) begin
      rx_pulse(8'h20 + 8'(i));
      chk($sformatf("irq_rx_cnt%0d", i + 1), {7'd0, irq}, (i == 3) ? 8'h01 : 8'h00);
    end
    rd(2'd0, 8'h20);
    chk("irq_after_read", {7'd0, irq}, 8'h00);
    for (int i = 1; i < 4; i++) rd(2'd0, 8'h20 + 8'(i));
    rd(2'd2, 8'h01);
    rd(2'd3, 8'h03);
    wr(2'd2, 8'h00);
    wr(2'd3, 8'h00);

    // Loopback: byte returns through RX, UART rx_ready ignored, no tx_req.
    wr(2'd2, 8'h20);
    wr(2'd0, 8'h5A);
    idle();
    rx_pulse(8'h77);
    rd(2'd0, 8'h5A);
    rd(2'd0, 8'h00);
    rd(2'd2, 8'h20);
    wr(2'd2, 8'h00);
    idle(2);

    // Flush while ACTIVE: in-flight byte completes, queued bytes are gone.
    exp_tx.push_back(8'hA1);
    wr(2'd0, 8'hA1);
    wr(2'd0, 8'hA2);
    wr(2'd0, 8'hA3);
    idle();
    wr(2'd2, 8'h08);
    rd(2'd1, 8'h54);
    rd(2'd2, 8'h00);
    tx_done();
    idle(5);
    rd(2'd1, 8'h54);
    idle(3);

    chk("rd_queue_drained", 8'(exp_rd.size()), 8'h00);
    chk("tx_queue_drained", 8'(exp_tx.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion, expected finish");
    $fatal(1, "timeout");
  end
endmodule
